// File: rtl/quad_pkg.sv
// Shared types and defaults for the quadcopter drive path: mixer state encoding,
// speed/mix widths, command payload and the default speed limits.
package quad_pkg;

  localparam int unsigned SPEED_W = 16;
  localparam int unsigned MIX_W   = 19;
  localparam int unsigned WD_W    = 24;
  localparam int unsigned NUM_CH  = 4;

  localparam logic [SPEED_W-1:0] DEF_MIN_SPEED      = 16'd2000;
  localparam logic [SPEED_W-1:0] DEF_MAX_SPEED      = 16'd60000;
  localparam logic [SPEED_W-1:0] DEF_FAILSAFE_SPEED = 16'd8000;
  localparam logic [WD_W-1:0]    DEF_TIMEOUT        = 24'd1_000_000;

  typedef logic [SPEED_W-1:0]      speed_t;
  typedef logic signed [MIX_W-1:0] mix_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SUM,
    ST_CLAMP,
    ST_DISPATCH
  } mix_state_e;

  typedef struct packed {
    speed_t throttle;
    speed_t roll;
    speed_t pitch;
    speed_t yaw;
  } flight_cmd_t;

  // Unsigned speed into the signed mix domain.
  function automatic mix_t zext_speed(input speed_t v);
    return mix_t'({{(MIX_W - SPEED_W){1'b0}}, v});
  endfunction

  // Signed 16-bit correction into the signed mix domain.
  function automatic mix_t sext_corr(input speed_t v);
    return mix_t'({{(MIX_W - SPEED_W){v[SPEED_W-1]}}, v});
  endfunction

  // Saturate a signed mix result into [lo, hi].
  function automatic speed_t clamp_speed(input mix_t m, input speed_t lo, input speed_t hi);
    mix_t lo_m;
    mix_t hi_m;
    lo_m = zext_speed(lo);
    hi_m = zext_speed(hi);
    if (m < lo_m) begin
      return lo;
    end else if (m > hi_m) begin
      return hi;
    end else begin
      return m[SPEED_W-1:0];
    end
  endfunction

endpackage

// File: rtl/mixer_channel_tx.sv
// One motor channel: pending speed register plus the busy / speed_oe load handshake
// towards its pwm instance.
module mixer_channel_tx
  import quad_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load,
  input  speed_t load_val,
  input  logic   dispatch_en,
  input  logic   busy,
  output logic   pending,
  output speed_t speed,
  output logic   speed_oe
);

  speed_t val_q;
  speed_t speed_q;
  logic   pending_q;

  // Strobe is gated by the same-cycle busy so a busy pwm never sees a load.
  assign speed_oe = dispatch_en & pending_q & ~busy;
  assign speed    = speed_oe ? val_q : speed_q;
  assign pending  = pending_q;

  // Comes out of reset pending at zero so the motors are pushed to stop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 1'b1;
      val_q     <= '0;
      speed_q   <= '0;
    end else begin
      if (speed_oe) begin
        speed_q <= val_q;
      end
      if (load) begin
        val_q     <= load_val;
        pending_q <= 1'b1;
      end else if (speed_oe) begin
        pending_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/motor_mixer.sv
// X-frame motor mixer: accepts flight commands, mixes and clamps four motor speeds,
// and dispatches them to the pwm channels with arming and command-loss failsafe.
module motor_mixer
  import quad_pkg::*;
#(
  parameter logic [SPEED_W-1:0] MIN_SPEED      = DEF_MIN_SPEED,
  parameter logic [SPEED_W-1:0] MAX_SPEED      = DEF_MAX_SPEED,
  parameter logic [SPEED_W-1:0] FAILSAFE_SPEED = DEF_FAILSAFE_SPEED,
  parameter logic [WD_W-1:0]    TIMEOUT        = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               arm,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [SPEED_W-1:0] throttle,
  input  logic [SPEED_W-1:0] roll,
  input  logic [SPEED_W-1:0] pitch,
  input  logic [SPEED_W-1:0] yaw,
  input  logic [NUM_CH-1:0]  busy,
  output logic [SPEED_W-1:0] speed0,
  output logic [SPEED_W-1:0] speed1,
  output logic [SPEED_W-1:0] speed2,
  output logic [SPEED_W-1:0] speed3,
  output logic [NUM_CH-1:0]  speed_oe,
  output logic               failsafe
);

  localparam logic [WD_W-1:0] WD_LAST = TIMEOUT - WD_W'(1);

  mix_state_e  state_q, state_d;
  flight_cmd_t cmd_q;
  mix_t        mix_q [NUM_CH];
  logic [WD_W-1:0] wd_q;
  logic        arm_q;
  logic        failsafe_q;
  logic        zero_pend_q;

  logic        accept;
  logic        fs_trig;
  logic        disarm_load;
  logic        load;
  speed_t      load_val [NUM_CH];
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] pend_left;
  logic        disarm_evt;
  logic        dispatch_en;
  speed_t      ch_speed [NUM_CH];

  mix_t t_x, r_x, p_x, y_x;

  assign disarm_evt  = arm_q & ~arm;
  assign dispatch_en = (state_q == ST_DISPATCH);
  assign pend_left   = pending & ~speed_oe;
  assign cmd_ready   = (state_q == ST_IDLE) & arm & ~(|pending);
  assign failsafe    = failsafe_q;

  assign t_x = zext_speed(cmd_q.throttle);
  assign r_x = sext_corr(cmd_q.roll);
  assign p_x = sext_corr(cmd_q.pitch);
  assign y_x = sext_corr(cmd_q.yaw);

  // Next-state and channel load control; a fresh disarm overrides everything.
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    fs_trig     = 1'b0;
    disarm_load = 1'b0;
    load        = 1'b0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      load_val[i] = '0;
    end

    if (disarm_evt && !zero_pend_q) begin
      disarm_load = 1'b1;
      load        = 1'b1;
      state_d     = ST_DISPATCH;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|pending) begin
            state_d = ST_DISPATCH;
          end else if (cmd_valid && cmd_ready) begin
            accept  = 1'b1;
            state_d = ST_SUM;
          end else if (arm && (wd_q == WD_LAST) && !failsafe_q) begin
            fs_trig = 1'b1;
            load    = 1'b1;
            for (int i = 0; i < int'(NUM_CH); i++) begin
              load_val[i] = FAILSAFE_SPEED;
            end
            state_d = ST_DISPATCH;
          end
        end
        ST_SUM: begin
          state_d = ST_CLAMP;
        end
        ST_CLAMP: begin
          load = 1'b1;
          for (int i = 0; i < int'(NUM_CH); i++) begin
            load_val[i] = clamp_speed(mix_q[i], MIN_SPEED, MAX_SPEED);
          end
          state_d = ST_DISPATCH;
        end
        ST_DISPATCH: begin
          if (pend_left == '0) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      arm_q       <= 1'b0;
      cmd_q       <= '0;
      wd_q        <= '0;
      failsafe_q  <= 1'b0;
      zero_pend_q <= 1'b0;
      for (int i = 0; i < int'(NUM_CH); i++) begin
        mix_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      arm_q   <= arm;

      if (accept) begin
        cmd_q <= {throttle, roll, pitch, yaw};
      end

      // X-frame mix: motors 0/1 front, 1/2 right-side roll, 1/3 positive yaw.
      if (state_q == ST_SUM) begin
        mix_q[0] <= t_x + p_x - r_x - y_x;
        mix_q[1] <= t_x + p_x + r_x + y_x;
        mix_q[2] <= t_x - p_x + r_x - y_x;
        mix_q[3] <= t_x - p_x - r_x + y_x;
      end

      // Watchdog saturates at its last count; the failsafe flag blocks reloads.
      if (!arm || accept) begin
        wd_q <= '0;
      end else if ((state_q == ST_IDLE) && (wd_q != WD_LAST)) begin
        wd_q <= wd_q + WD_W'(1);
      end

      if (!arm || accept) begin
        failsafe_q <= 1'b0;
      end else if (fs_trig) begin
        failsafe_q <= 1'b1;
      end

      if (disarm_load) begin
        zero_pend_q <= 1'b1;
      end else if (state_d == ST_IDLE) begin
        zero_pend_q <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_ch
    mixer_channel_tx u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .load        (load),
      .load_val    (load_val[i]),
      .dispatch_en (dispatch_en),
      .busy        (busy[i]),
      .pending     (pending[i]),
      .speed       (ch_speed[i]),
      .speed_oe    (speed_oe[i])
    );
  end

  assign speed0 = ch_speed[0];
  assign speed1 = ch_speed[1];
  assign speed2 = ch_speed[2];
  assign speed3 = ch_speed[3];

endmodule

// File: doc/motor_mixer.md
Name: motor_mixer

Overview:
- Upstream stage of the four pwm channels in the quadcopter drive path.
- Accepts one flight command per handshake: unsigned throttle plus signed roll, pitch and yaw corrections from the attitude controller.
- Mixes the command into four X-frame motor speeds, clamps each, and dispatches each speed to its pwm instance through that instance's speed_in / speed_oe / busy interface.
- Owns arming, disarm-to-zero and a command-loss watchdog that forces a failsafe speed.

Parameters:
- MIN_SPEED, 16'd2000: lowest speed sent while armed (idle spin); mixed values below it are clamped up.
- MAX_SPEED, 16'd60000: highest speed sent; mixed values above it are clamped down.
- FAILSAFE_SPEED, 16'd8000: speed sent to all motors on watchdog timeout.
- TIMEOUT, 24'd1_000_000: armed cycles without an accepted command before failsafe (10 ms at 100 MHz).

Ports:
- clk  in  1  system clock, single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- arm  in  1  level; 1 = armed, 0 = disarmed (motors commanded to 0).
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command this cycle.
- throttle  in  16  unsigned base speed.
- roll  in  16  signed correction.
- pitch  in  16  signed correction.
- yaw  in  16  signed correction.
- busy  in  4  busy[i] from pwm instance i.
- speed0..speed3  out  16 each  speed_in for pwm instances 0..3.
- speed_oe  out  4  one-cycle load strobe per channel.
- failsafe  out  1  high while in failsafe.

Behaviour:
- Reset (async, rst_n=0): all speedN=0, speed_oe=0, cmd_ready=0, failsafe=0, watchdog=0, state=IDLE. First cycle after reset is IDLE with all four channels marked pending at speed 0, so zero is pushed to the motors.
- States: IDLE, SUM, CLAMP, DISPATCH.
- IDLE:
  - cmd_ready=1 only when arm=1 and no channel is pending.
  - Handshake: cmd_valid & cmd_ready latches the four inputs and moves to SUM.
- SUM (cycle +1): register the mix, 19-bit signed, throttle zero-extended, corrections sign-extended:
  - m0 = T + P - R - Y
  - m1 = T + P + R + Y
  - m2 = T - P + R - Y
  - m3 = T - P - R + Y
- CLAMP (cycle +2): each m < MIN_SPEED becomes MIN_SPEED; m > MAX_SPEED becomes MAX_SPEED. Write to the pending speed registers and set all four pending bits.
- DISPATCH, per channel i with pending[i]=1:
  - If busy[i]=0: drive speedi = pending value and pulse speed_oe[i] for exactly one cycle, then clear pending[i].
  - If busy[i]=1: wait. Channels are independent, so an idle channel is never held back by a busy one.
  - speedi holds its value until that channel's next load.
  - When all pending bits are clear, go to IDLE.
  - Best case: speed_oe fires on cycle +3 after acceptance; cmd_ready returns on cycle +4.
- Disarm (arm 1->0) at any point:
  - Abort SUM/CLAMP and discard the command.
  - Overwrite all pending values with 0, set all pending bits, go to DISPATCH.
  - A new disarm while zeros are pending causes no change.
  - A disarm coinciding with an accept takes priority: the command is dropped.
- Watchdog:
  - Counts while arm=1 and state=IDLE; clears on every accepted command and while disarmed.
  - Reaching TIMEOUT-1: load FAILSAFE_SPEED into all four pending registers, set failsafe=1, go to DISPATCH.
  - Counter then saturates; no repeated reloads.
  - failsafe clears on the next accepted command or on disarm.
- speed_oe never asserts on a channel whose busy is 1 in the same cycle, and never asserts while rst_n=0.
- Reset mid-operation: all state is lost and the post-reset zero push repeats.

Decomposition:
- Shared package (quad_pkg):
  - State encoding.
  - Speed width (16), mix width (19).
  - Default MIN/MAX/FAILSAFE constants, reused by pwm-side benches.
- One natural sub-module: mixer_channel_tx, instantiated 4×. It holds one channel's pending bit and speed register and runs the busy/speed_oe handshake.

Test Plan:
- Reset, then arm=1, T=30000, R=P=Y=0, busy=0 -> speed0..3=30000, speed_oe=4'b1111 for one cycle at acceptance+3, cmd_ready high at +4.
- T=30000, R=1000, P=Y=0 -> speed0=29000, speed1=31000, speed2=31000, speed3=29000.
- T=59000, P=5000, Y=1000 -> m1=65000 clamps to 60000; second command T=1000, R=P=Y=0 -> all 2000.
- busy[2]=1 for 20 cycles during dispatch -> oe[0,1,3] pulse at +3; oe[2] pulses the first cycle busy[2]=0; cmd_ready stays low until then.
- Drop arm while in SUM -> command discarded; all speeds loaded with 0 via speed_oe; cmd_ready stays 0 while disarmed.
- TIMEOUT=100, armed, no cmd_valid -> at cycle 100 all speeds=8000, failsafe=1; a subsequent accepted command clears failsafe.
